// File: rtl/irda_mir_rx_frame_ctrl.sv
// irda_mir_rx_frame_ctrl
//   Frame-level sequencer for the MIR receive path. It restarts the MIR bit
//   receiver, gates the receiver's word pushes into the RX data FIFO and
//   polices each frame for break, FIFO overflow, excessive length and,
//   optionally, idle timeout. For every frame it logs one 32-bit status
//   record into a small FIFO that the Wishbone register block reads.
//
//   Optional feature: define IRDA_MIR_RX_TIMEOUT_EN to enable the idle-timeout
//   abort. Without it there is no idle counter, TIMEOUT is unused and record
//   bit 20 is always 0.
//
// Parameters
//   STAT_AW    status queue address width (depth 2**STAT_AW records, >= 1)
//   MAX_WORDS  words accepted per frame; the next word aborts (too_long)
//   TIMEOUT    idle bit strobes in FRAME before a timeout abort
//
// Ports
//   clk, wb_rst_i        clock, synchronous active-high reset
//   rx_en                host receive enable
//   mir_rxbit_enable     MIR bit-rate strobe
//   rxfifo_add_i         word push request from the bit receiver
//   rxfifo_full          RX data FIFO full
//   mir_sto_detected     end-of-frame flag (one bit period)
//   mir_crc_error        CRC result, valid on the clk after sto falls
//   mir_rx_error         break condition
//   mir_ifdlr_i[15:0]    received frame length in bytes
//   rxfifo_push          gated push to the RX data FIFO
//   mir_rx_restart       restart to the bit receiver
//   stat_rd              pop status record
//   stat_dat_o[31:0]     head status record (0 when empty)
//   stat_valid           status queue not empty
//   stat_count           records held
//   rx_busy              frame in progress (FRAME or WAIT_CRC)
//   rx_int               one-clk pulse per record written
//
// Status record
//   [15:0] len, [16] crc_err, [17] brk, [18] ovf, [19] too_long,
//   [20] timeout, [21] lost, [27:24] seq, other bits 0
//
// state    | meaning
// DISABLED | receiver held in restart, waiting for rx_en
// RESTART  | one-clk receiver restart before hunting
// HUNT     | waiting for the first word or an empty frame's stop flag
// FRAME    | receiving words, counting length (and idle strobes)
// WAIT_CRC | stop flag seen, waiting for it to fall to sample CRC
// LOG      | write the good-frame record
// ABORT    | restart receiver and write the error record
module irda_mir_rx_frame_ctrl #(
  parameter int STAT_AW   = 2,
  parameter int MAX_WORDS = 512,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               wb_rst_i,
  input  logic               rx_en,
  input  logic               mir_rxbit_enable,
  input  logic               rxfifo_add_i,
  input  logic               rxfifo_full,
  input  logic               mir_sto_detected,
  input  logic               mir_crc_error,
  input  logic               mir_rx_error,
  input  logic [15:0]        mir_ifdlr_i,
  output logic               rxfifo_push,
  output logic               mir_rx_restart,
  input  logic               stat_rd,
  output logic [31:0]        stat_dat_o,
  output logic               stat_valid,
  output logic [STAT_AW:0]   stat_count,
  output logic               rx_busy,
  output logic               rx_int
);

  localparam logic [2:0] ST_DISABLED = 3'd0;
  localparam logic [2:0] ST_RESTART  = 3'd1;
  localparam logic [2:0] ST_HUNT     = 3'd2;
  localparam logic [2:0] ST_FRAME    = 3'd3;
  localparam logic [2:0] ST_WAIT_CRC = 3'd4;
  localparam logic [2:0] ST_LOG      = 3'd5;
  localparam logic [2:0] ST_ABORT    = 3'd6;

  localparam int WCW   = $clog2(MAX_WORDS + 1);
  localparam int DEPTH = 2 ** STAT_AW;

  logic [2:0]         state, state_nxt;
  logic [WCW-1:0]     word_cnt;
  logic               crc_err_q;
  logic [3:0]         cause_q;     // {timeout, too_long, ovf, brk}
  logic [3:0]         seq;
  logic               lost;

  logic [31:0]        stat_mem [DEPTH];
  logic [STAT_AW-1:0] wr_ptr, rd_ptr;
  logic [STAT_AW:0]   count;

  logic               in_rx;
  logic               word_full;
  logic               c_brk, c_ovf, c_long, c_tmo;
  logic               abort_any;
  logic [3:0]         cause_nxt;
  logic [31:0]        wbytes;
  logic [15:0]        abort_len;
  logic [31:0]        record;
  logic               wr_req, wr_acc, pop;

  assign in_rx     = (state == ST_HUNT) || (state == ST_FRAME) || (state == ST_WAIT_CRC);
  assign word_full = (word_cnt == WCW'(MAX_WORDS));

  assign c_brk  = mir_rx_error;
  assign c_ovf  = rxfifo_add_i & rxfifo_full;
  assign c_long = rxfifo_add_i & word_full;

`ifdef IRDA_MIR_RX_TIMEOUT_EN
  localparam int ICW = $clog2(TIMEOUT) + 1;
  logic [ICW-1:0] idle_cnt;

  // Abort on the strobe that brings the idle count up to TIMEOUT.
  assign c_tmo = (state == ST_FRAME) & mir_rxbit_enable & ~rxfifo_add_i &
                 (idle_cnt == ICW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (wb_rst_i || state != ST_FRAME || rxfifo_add_i)
      idle_cnt <= '0;
    else if (mir_rxbit_enable)
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_strobe;
  assign unused_strobe = mir_rxbit_enable;
  assign c_tmo = 1'b0;
`endif

  assign abort_any = c_brk | c_ovf | c_long | c_tmo;

  // Only the highest-priority cause is reported.
  always_comb begin
    cause_nxt = 4'b0000;
    if (c_brk)       cause_nxt = 4'b0001;
    else if (c_ovf)  cause_nxt = 4'b0010;
    else if (c_long) cause_nxt = 4'b0100;
    else if (c_tmo)  cause_nxt = 4'b1000;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_DISABLED) begin
      if (rx_en) state_nxt = ST_RESTART;
    end else if (!rx_en) begin
      state_nxt = ST_DISABLED;
    end else begin
      case (state)
        ST_RESTART:  state_nxt = ST_HUNT;
        ST_HUNT: begin
          if (abort_any)             state_nxt = ST_ABORT;
          else if (mir_sto_detected) state_nxt = ST_WAIT_CRC;
          else if (rxfifo_add_i)     state_nxt = ST_FRAME;
        end
        ST_FRAME: begin
          if (abort_any)             state_nxt = ST_ABORT;
          else if (mir_sto_detected) state_nxt = ST_WAIT_CRC;
        end
        ST_WAIT_CRC: begin
          if (abort_any)              state_nxt = ST_ABORT;
          else if (!mir_sto_detected) state_nxt = ST_LOG;
        end
        ST_LOG:      state_nxt = ST_HUNT;
        ST_ABORT:    state_nxt = ST_HUNT;
        default:     state_nxt = ST_DISABLED;
      endcase
    end
  end

  assign rxfifo_push    = rxfifo_add_i & ~rxfifo_full & in_rx & ~word_full;
  assign mir_rx_restart = (state == ST_DISABLED) || (state == ST_RESTART) || (state == ST_ABORT);
  assign rx_busy        = (state == ST_FRAME) || (state == ST_WAIT_CRC);

  assign wbytes    = 32'(word_cnt) << 2;
  assign abort_len = (wbytes > 32'h0000_FFFF) ? 16'hFFFF : wbytes[15:0];

  always_comb begin
    record = 32'h0;
    record[27:24] = seq;
    record[21]    = lost;
    if (state == ST_ABORT) begin
      record[15:0]  = abort_len;
      record[20:17] = cause_q;
    end else begin
      record[15:0]  = mir_ifdlr_i;
      record[16]    = crc_err_q;
    end
  end

  // Read-first queue: a pop frees the slot a same-clk write may use.
  assign pop    = stat_rd && (count != '0);
  assign wr_req = rx_en && ((state == ST_LOG) || (state == ST_ABORT));
  assign wr_acc = wr_req && ((count != (STAT_AW+1)'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state     <= ST_DISABLED;
      word_cnt  <= '0;
      crc_err_q <= 1'b0;
      cause_q   <= 4'b0000;
      seq       <= 4'd0;
      lost      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rx_int    <= 1'b0;
    end else begin
      state  <= state_nxt;
      rx_int <= wr_acc;

      if (!in_rx)
        word_cnt <= '0;
      else if (rxfifo_push)
        word_cnt <= word_cnt + 1'b1;

      if (state == ST_WAIT_CRC && !mir_sto_detected)
        crc_err_q <= mir_crc_error;

      if (in_rx && abort_any)
        cause_q <= cause_nxt;

      if (wr_req) begin
        seq <= seq + 4'd1;
        if (wr_acc) lost <= 1'b0;
        else        lost <= 1'b1;
      end

      if (wr_acc) begin
        stat_mem[wr_ptr] <= record;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({wr_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign stat_count = count;
  assign stat_valid = (count != '0);
  assign stat_dat_o = (count != '0) ? stat_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_irda_mir_rx_frame_ctrl.sv
module tb_irda_mir_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        rx_en = 1'b0;
  logic        mir_rxbit_enable = 1'b0;
  logic        rxfifo_add_i = 1'b0;
  logic        rxfifo_full = 1'b0;
  logic        mir_sto_detected = 1'b0;
  logic        mir_crc_error = 1'b0;
  logic        mir_rx_error = 1'b0;
  logic [15:0] mir_ifdlr_i = 16'h0;
  logic        rxfifo_push;
  logic        mir_rx_restart;
  logic        stat_rd = 1'b0;
  logic [31:0] stat_dat_o;
  logic        stat_valid;
  logic [1:0]  stat_count;
  logic        rx_busy;
  logic        rx_int;

  int tests = 0;
  int fails = 0;
  int push_cnt = 0;
  int int_cnt = 0;
  int p0, i0;

`ifdef IRDA_MIR_RX_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  irda_mir_rx_frame_ctrl #(.STAT_AW(1), .MAX_WORDS(4), .TIMEOUT(8)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .rx_en(rx_en),
    .mir_rxbit_enable(mir_rxbit_enable), .rxfifo_add_i(rxfifo_add_i),
    .rxfifo_full(rxfifo_full), .mir_sto_detected(mir_sto_detected),
    .mir_crc_error(mir_crc_error), .mir_rx_error(mir_rx_error),
    .mir_ifdlr_i(mir_ifdlr_i), .rxfifo_push(rxfifo_push),
    .mir_rx_restart(mir_rx_restart), .stat_rd(stat_rd),
    .stat_dat_o(stat_dat_o), .stat_valid(stat_valid),
    .stat_count(stat_count), .rx_busy(rx_busy), .rx_int(rx_int)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rxfifo_push) push_cnt <= push_cnt + 1;
    if (rx_int)      int_cnt  <= int_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    step();   // DISABLED -> RESTART
    step();   // RESTART -> HUNT
  endtask

  task automatic pop_one();
    stat_rd = 1'b1;
    step();
    stat_rd = 1'b0;
  endtask

  // Empty frame from HUNT: stop flag, fall, LOG write.
  task automatic log_frame(input logic [15:0] len);
    mir_sto_detected = 1'b1;
    step();
    mir_sto_detected = 1'b0;
    mir_ifdlr_i = len;
    step();
    step();
  endtask

  initial begin
    step();
    step();
    chk("rst_restart", 32'(mir_rx_restart), 32'd1);
    chk("rst_push",    32'(rxfifo_push),    32'd0);
    chk("rst_valid",   32'(stat_valid),     32'd0);
    chk("rst_count",   32'(stat_count),     32'd0);
    chk("rst_dat",     stat_dat_o,          32'h0);
    chk("rst_busy",    32'(rx_busy),        32'd0);
    chk("rst_int",     32'(rx_int),         32'd0);

    wb_rst_i = 1'b0;
    rx_en = 1'b1;
    step();
    chk("restart_state", 32'(mir_rx_restart), 32'd1);
    step();
    chk("hunt_restart", 32'(mir_rx_restart), 32'd0);

    // Good frame: 3 words, length 12, CRC ok.
    p0 = push_cnt; i0 = int_cnt;
    rxfifo_add_i = 1'b1;
    step(); step(); step();
    rxfifo_add_i = 1'b0;
    chk("t1_busy", 32'(rx_busy), 32'd1);
    mir_sto_detected = 1'b1;
    step(); step();
    mir_sto_detected = 1'b0;
    mir_crc_error = 1'b0;
    mir_ifdlr_i = 16'd12;
    step();
    chk("t1_not_yet", 32'(stat_valid), 32'd0);
    step();
    chk("t1_int",    32'(rx_int),     32'd1);
    chk("t1_count",  32'(stat_count), 32'd1);
    chk("t1_record", stat_dat_o,      32'h0000_000C);
    step();
    chk("t1_int_one",  32'(int_cnt - i0),  32'd1);
    chk("t1_pushes",   32'(push_cnt - p0), 32'd3);
    pop_one();
    chk("t1_popped", 32'(stat_count), 32'd0);
    chk("t1_empty_dat", stat_dat_o, 32'h0);

    // Overflow on word 2.
    do_reset();
    p0 = push_cnt;
    rxfifo_add_i = 1'b1;
    step();
    rxfifo_full = 1'b1;
    #1;
    chk("t2_no_push", 32'(rxfifo_push), 32'd0);
    step();
    rxfifo_add_i = 1'b0;
    rxfifo_full = 1'b0;
    chk("t2_restart", 32'(mir_rx_restart), 32'd1);
    step();
    chk("t2_restart_off", 32'(mir_rx_restart), 32'd0);
    chk("t2_int",    32'(rx_int), 32'd1);
    chk("t2_record", stat_dat_o,  32'h0004_0004);
    chk("t2_pushes", 32'(push_cnt - p0), 32'd1);
    mir_crc_error = 1'b1;
    log_frame(16'd0);
    mir_crc_error = 1'b0;
    chk("t2_count2", 32'(stat_count), 32'd2);
    pop_one();
    chk("t2_next_seq", stat_dat_o, 32'h0101_0000);
    pop_one();

    // Too long: MAX_WORDS=4, fifth word dropped.
    p0 = push_cnt;
    rxfifo_add_i = 1'b1;
    step(); step(); step(); step();
    #1;
    chk("t3_drop", 32'(rxfifo_push), 32'd0);
    step();
    rxfifo_add_i = 1'b0;
    step();
    chk("t3_record", stat_dat_o, 32'h0208_0010);
    chk("t3_pushes", 32'(push_cnt - p0), 32'd4);
    chk("t3_hunt_busy", 32'(rx_busy), 32'd0);
    chk("t3_hunt_restart", 32'(mir_rx_restart), 32'd0);
    pop_one();

    // Queue overflow with a depth-2 queue.
    do_reset();
    log_frame(16'd1);
    log_frame(16'd2);
    log_frame(16'd3);
    chk("t4_drop_int", 32'(rx_int),     32'd0);
    chk("t4_count",    32'(stat_count), 32'd2);
    chk("t4_head0",    stat_dat_o,      32'h0000_0001);
    pop_one();
    chk("t4_head1",    stat_dat_o,      32'h0100_0002);
    log_frame(16'd4);
    chk("t4_count2",   32'(stat_count), 32'd2);
    pop_one();
    chk("t4_lost_rec", stat_dat_o,      32'h0320_0004);
    pop_one();

    // Break with simultaneous overflow: break wins.
    rxfifo_add_i = 1'b1;
    step();
    rxfifo_full = 1'b1;
    mir_rx_error = 1'b1;
    step();
    rxfifo_add_i = 1'b0;
    rxfifo_full = 1'b0;
    mir_rx_error = 1'b0;
    step();
    chk("t5_brk_rec", stat_dat_o, 32'h0402_0004);
    pop_one();

    // rx_en dropped mid-frame: no record, restart held.
    i0 = int_cnt;
    rxfifo_add_i = 1'b1;
    step();
    rxfifo_add_i = 1'b0;
    rx_en = 1'b0;
    step();
    chk("t5_dis_restart", 32'(mir_rx_restart), 32'd1);
    chk("t5_dis_busy",    32'(rx_busy),        32'd0);
    step(); step();
    chk("t5_dis_hold",  32'(mir_rx_restart), 32'd1);
    chk("t5_dis_count", 32'(stat_count),     32'd0);
    chk("t5_dis_int",   32'(int_cnt - i0),   32'd0);
    rx_en = 1'b1;
    step(); step();

    // Idle timeout: one word then 8 idle strobes.
    do_reset();
    rxfifo_add_i = 1'b1;
    step();
    rxfifo_add_i = 1'b0;
    mir_rxbit_enable = 1'b1;
    for (int k = 0; k < 8; k++) step();
    mir_rxbit_enable = 1'b0;
    chk("t6_restart", 32'(mir_rx_restart), TMO ? 32'd1 : 32'd0);
    step();
    chk("t6_count",  32'(stat_count), TMO ? 32'd1 : 32'd0);
    chk("t6_record", stat_dat_o,      TMO ? 32'h0010_0004 : 32'h0);
    chk("t6_busy",   32'(rx_busy),    TMO ? 32'd0 : 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
